// File: rtl/tzbus_pkg.sv
// Shared types and constants for the tzbus serial receiver.
package tzbus_pkg;

  localparam int unsigned OSR_DEF = 8;
  localparam int unsigned DW_DEF  = 8;

  // LINE is inverted: a released (idle) line reads low, i.e. logical 1
  localparam logic IDLE_LINE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/tzbus_rx_if.sv
// Receive-side bundle: serial line in, received word with valid/ready handshake out.
interface tzbus_rx_if
  import tzbus_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);
  logic          line;
  logic          ready;
  logic [DW-1:0] data;
  logic          valid;
  logic          ferr;
  logic          ovr;
  logic          busy;

  modport master (input line, input ready, output data, output valid,
                  output ferr, output ovr, output busy);
  modport slave  (output line, output ready, input data, input valid,
                  input ferr, input ovr, input busy);
endinterface

// File: rtl/tzbus_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module tzbus_rx_sync
  import tzbus_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= IDLE_LINE;
      r_sync <= IDLE_LINE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/tzbus_rx.sv
// Oversampling receiver for the inverted-polarity tzbus line with a one-word
// valid/ready output buffer, framing-error and overrun pulses.
module tzbus_rx
  import tzbus_pkg::*;
#(
  parameter int unsigned OSR = OSR_DEF,
  parameter int unsigned DW  = DW_DEF
) (
  input  logic          CLK,
  input  logic          RN,
  input  logic          LINE,
  input  logic          READY,
  output logic [DW-1:0] DATA,
  output logic          VALID,
  output logic          FERR,
  output logic          OVR,
  output logic          BUSY,
  inout  wire           VDD,
  inout  wire           VSS
);
  localparam int unsigned CW = $clog2(OSR);
  localparam int unsigned BW = $clog2(DW);
  localparam logic [CW-1:0] CNT_HALF = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OSR - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  rx_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [BW-1:0] r_bitcnt, w_bitcnt_nxt;
  logic [DW-1:0] r_shift, w_shift_nxt;
  logic [DW-1:0] r_data, w_data_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_ferr, w_ferr_nxt;
  logic          r_ovr, w_ovr_nxt;
  logic          r_busy;
  logic          r_armed, w_armed_nxt;
  logic [1:0]    r_warm;
  logic          w_line_sync;
  logic          w_bit;
  logic          w_good;
  logic          w_unused;

  assign w_unused = &{1'b0, VDD, VSS};

  tzbus_rx_sync u_sync (
    .clk   (CLK),
    .rst_n (RN),
    .i_d   (LINE),
    .o_q   (w_line_sync)
  );

  assign w_bit = ~w_line_sync;

  // A start needs a real 1->0 edge: arming waits until the synchronizer has
  // flushed its reset value, so a line already busy at reset release is ignored.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_armed_nxt  = r_armed;
    w_good       = 1'b0;
    w_ferr_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (r_warm[1] && w_bit) w_armed_nxt = 1'b1;
        if (r_armed && !w_bit) begin
          w_state_nxt = ST_START;
          w_armed_nxt = 1'b0;
        end
      end
      ST_START: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt    = '0;
          w_bitcnt_nxt = '0;
          w_state_nxt  = w_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CNT_MID) begin
          w_cnt_nxt    = '0;
          w_shift_nxt  = {w_bit, r_shift[DW-1:1]};
          w_bitcnt_nxt = r_bitcnt + BW'(1);
          if (r_bitcnt == BIT_LAST) begin
            w_bitcnt_nxt = '0;
            w_state_nxt  = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CNT_MID) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          w_good      = w_bit;
          w_ferr_nxt  = ~w_bit;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Output buffer: a completing frame may refill in the same cycle the word is consumed
    w_valid_nxt = r_valid && !READY;
    w_data_nxt  = r_data;
    w_ovr_nxt   = 1'b0;
    if (w_good) begin
      if (!r_valid || READY) begin
        w_data_nxt  = r_shift;
        w_valid_nxt = 1'b1;
      end else begin
        w_ovr_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
      r_busy   <= 1'b0;
      r_armed  <= 1'b0;
      r_warm   <= 2'b00;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_ferr   <= w_ferr_nxt;
      r_ovr    <= w_ovr_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_armed  <= w_armed_nxt;
      r_warm   <= {r_warm[0], 1'b1};
    end
  end

  assign DATA  = r_data;
  assign VALID = r_valid;
  assign FERR  = r_ferr;
  assign OVR   = r_ovr;
  assign BUSY  = r_busy;
endmodule

// File: tb/tb_tzbus_rx.sv
// Randomized and directed frame stimulus for tzbus_rx, checked every cycle
// against a frame-level reference model of the receiver's observable behaviour.
module tb_tzbus_rx;
  import tzbus_pkg::*;

  localparam int unsigned OSR = 8;
  localparam int unsigned DW  = 8;
  // start edge -> stop-bit mid-sample, plus the two synchronizer cycles
  localparam int LAT        = 2 + OSR / 2 + OSR * (DW + 1);
  localparam int GLITCH_END = 2 + OSR / 2;

  localparam int K_NONE    = 0;
  localparam int K_GOOD    = 1;
  localparam int K_BADSTOP = 2;
  localparam int K_GLITCH  = 3;

  typedef struct {
    bit            b;
    int            kind;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    int            cyc;
    bit            good;
    logic [DW-1:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rn  = 1'b1;
  wire  vdd;
  wire  vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  tzbus_rx_if #(.DW(DW)) bus ();

  tzbus_rx #(.OSR(OSR), .DW(DW)) dut (
    .CLK   (clk),
    .RN    (rn),
    .LINE  (bus.line),
    .READY (bus.ready),
    .DATA  (bus.data),
    .VALID (bus.valid),
    .FERR  (bus.ferr),
    .OVR   (bus.ovr),
    .BUSY  (bus.busy),
    .VDD   (vdd),
    .VSS   (vss)
  );

  always #5 clk = ~clk;

  ent_t          line_q[$];
  ev_t           ev_q[$];
  int            cyc      = 0;
  int            n_tests  = 0;
  int            n_fail   = 0;
  int            rdy_mode = 0;
  int            busy_lo  = 0;
  int            busy_hi  = 0;
  logic          m_valid  = 1'b0;
  logic [DW-1:0] m_data   = '0;
  logic          exp_ferr = 1'b0;
  logic          exp_ovr  = 1'b0;
  logic          exp_busy = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_run(input bit b, input int kind, input logic [DW-1:0] d, input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e.b    = b;
      e.kind = (i == 0) ? kind : K_NONE;
      e.d    = d;
      line_q.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] d, input bit stop_ok, input int tail);
    push_run(1'b0, stop_ok ? K_GOOD : K_BADSTOP, d, OSR);
    for (int i = 0; i < int'(DW); i++) push_run(d[i], K_NONE, '0, OSR);
    push_run(stop_ok, K_NONE, '0, OSR);
    push_run(1'b1, K_NONE, '0, tail);
  endtask

  task automatic push_glitch();
    push_run(1'b0, K_GLITCH, '0, 3);
    push_run(1'b1, K_NONE, '0, 2 * OSR);
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge,
  // compare at the next falling edge.
  task automatic step(input bit rst_pulse);
    ent_t e;
    ev_t  ev;
    bit   rdy;
    if (line_q.size() > 0) begin
      e = line_q.pop_front();
    end else begin
      e.b = 1'b1; e.kind = K_NONE; e.d = '0;
    end
    bus.line = ~e.b;
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = (ev_q.size() > 0) && (ev_q[0].cyc == cyc + 1);
    endcase
    bus.ready = rdy;
    rn = ~rst_pulse;
    if (rst_pulse) begin
      #1;
      chk_eq("rst_valid", 32'(bus.valid), 32'd0);
      chk_eq("rst_data",  32'(bus.data),  32'd0);
      chk_eq("rst_ferr",  32'(bus.ferr),  32'd0);
      chk_eq("rst_ovr",   32'(bus.ovr),   32'd0);
      chk_eq("rst_busy",  32'(bus.busy),  32'd0);
      ev_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      busy_hi = 0;
    end
    @(posedge clk);
    cyc++;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (!rst_pulse) begin
      if (e.kind == K_GLITCH) begin
        busy_lo = cyc + 2;
        busy_hi = cyc + GLITCH_END;
      end else if (e.kind != K_NONE) begin
        busy_lo = cyc + 2;
        busy_hi = cyc + LAT;
        ev.cyc  = cyc + LAT;
        ev.good = (e.kind == K_GOOD);
        ev.d    = e.d;
        ev_q.push_back(ev);
      end
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        ev = ev_q.pop_front();
        if (ev.good) begin
          if (!m_valid || rdy) begin
            m_data  = ev.d;
            m_valid = 1'b1;
          end else begin
            exp_ovr = 1'b1;
          end
        end else begin
          exp_ferr = 1'b1;
          if (m_valid && rdy) m_valid = 1'b0;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    exp_busy = (cyc >= busy_lo) && (cyc < busy_hi);
    @(negedge clk);
    chk_eq("valid", 32'(bus.valid), 32'(m_valid));
    chk_eq("data",  32'(bus.data),  32'(m_data));
    chk_eq("ferr",  32'(bus.ferr),  32'(exp_ferr));
    chk_eq("ovr",   32'(bus.ovr),   32'(exp_ovr));
    chk_eq("busy",  32'(bus.busy),  32'(exp_busy));
  endtask

  task automatic drain(input int extra);
    while (line_q.size() > 0) step(1'b0);
    for (int i = 0; i < extra; i++) step(1'b0);
  endtask

  initial begin
    bus.line  = IDLE_LINE;
    bus.ready = 1'b0;
    #2;
    step(1'b1);
    step(1'b1);
    drain(10);

    // well-formed frame, consumer always ready
    rdy_mode = 1;
    push_frame(8'hA5, 1'b1, 2 * OSR);
    drain(4);

    // held word, then overrun on the second frame
    rdy_mode = 0;
    push_frame(8'h3C, 1'b1, OSR);
    push_frame(8'h81, 1'b1, OSR);
    drain(4);
    rdy_mode = 1;
    drain(4);

    // bad stop bit
    push_frame(8'h55, 1'b0, 2 * OSR);
    drain(4);

    // short line pulse: false start
    push_glitch();
    drain(4);

    // reset during data bit 4, remaining bits never form a fresh start edge
    rdy_mode = 0;
    push_frame(8'h0F, 1'b1, 2 * OSR);
    for (int i = 0; i < int'(OSR * 5 + 3); i++) step(1'b0);
    step(1'b1);
    drain(4);
    rdy_mode = 1;
    push_frame(8'hF0, 1'b1, 2 * OSR);
    drain(4);

    // READY only in the completion cycles: second frame refills without overrun
    rdy_mode = 3;
    push_frame(8'h34, 1'b1, OSR);
    push_frame(8'h12, 1'b1, OSR);
    drain(4);
    rdy_mode = 1;
    drain(4);

    // randomized frames, gaps, stop errors and consumer backpressure
    rdy_mode = 2;
    for (int n = 0; n < 24; n++) begin
      logic [DW-1:0] d;
      bit            ok;
      d  = DW'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      push_frame(d, ok, ok ? int'($urandom_range(0, 16)) : int'($urandom_range(2, 16)));
      if ($urandom_range(0, 7) == 0) push_glitch();
    end
    drain(8);
    rdy_mode = 1;
    drain(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
